// File: rtl/adder_array_pipe_pkg.sv
// Shared definitions for the adder array: default parameter values,
// the operation encoding and the cmd decoding rule (CMD_ALL = NUM_CH).
package adder_array_pipe_pkg;

  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_CMD_W     = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // The cmd value that enables every channel at once.
  function automatic int cmd_all(input int num_ch);
    return num_ch;
  endfunction

  // A lane is enabled when cmd names it directly or names all channels.
  // Any other cmd value is a no-op that still travels down the pipe.
  function automatic logic lane_enabled(input int cmd_val, input int lane, input int num_ch);
    return (cmd_val == lane) || (cmd_val == cmd_all(num_ch));
  endfunction

endpackage

// File: rtl/adder_array_pipe_lane.sv
// Single-channel two-stage split adder. Stage 1 adds the low half and keeps
// the carry plus the (possibly inverted) high operands; stage 2 finishes the
// high half and derives the unsigned carry/borrow flag.
module adder_lane
  import adder_array_pipe_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s1_load,
  input  logic                 s2_load,
  input  logic                 en,
  input  op_e                  op,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic [BIT_WIDTH-1:0] dout,
  output logic                 overflow
);

  localparam int HALF = BIT_WIDTH / 2;

  logic [BIT_WIDTH-1:0] b_eff;
  logic [HALF:0]        lo_sum;
  logic [HALF:0]        hi_sum;
  logic [HALF-1:0]      lo_q;
  logic [HALF-1:0]      a_hi_q;
  logic [HALF-1:0]      b_hi_q;
  logic                 carry_q;
  logic                 en_q;
  op_e                  op_q;
  logic                 ovf_next;

  // Subtraction is a + ~b + 1: invert b here and inject the +1 as carry-in.
  assign b_eff  = (op == OP_SUB) ? ~b : b;
  assign lo_sum = {1'b0, a[HALF-1:0]} + {1'b0, b_eff[HALF-1:0]} + {{HALF{1'b0}}, (op == OP_SUB)};

  // Stage 1: capture the low-half sum, its carry and the high operands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q    <= '0;
      carry_q <= 1'b0;
      a_hi_q  <= '0;
      b_hi_q  <= '0;
      en_q    <= 1'b0;
      op_q    <= OP_ADD;
    end else if (s1_load) begin
      lo_q    <= lo_sum[HALF-1:0];
      carry_q <= lo_sum[HALF];
      a_hi_q  <= a[BIT_WIDTH-1:HALF];
      b_hi_q  <= b_eff[BIT_WIDTH-1:HALF];
      en_q    <= en;
      op_q    <= op;
    end
  end

  assign hi_sum = {1'b0, a_hi_q} + {1'b0, b_hi_q} + {{HALF{1'b0}}, carry_q};
  // A missing carry-out on subtract means the result borrowed.
  assign ovf_next = (op_q == OP_SUB) ? ~hi_sum[HALF] : hi_sum[HALF];

  // Stage 2: finish the high half; a disabled lane reports zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout     <= '0;
      overflow <= 1'b0;
    end else if (s2_load) begin
      dout     <= en_q ? {hi_sum[HALF-1:0], lo_q} : '0;
      overflow <= en_q & ovf_next;
    end
  end

endmodule

// File: rtl/adder_array_pipe.sv
// Array of NUM_CH split adders behind one valid/ready pipeline. The
// handshake, stage valid bits and the saturating overflow counter are shared
// by all lanes; the lanes only hold datapath registers.
module adder_array_pipe
  import adder_array_pipe_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CMD_W     = DEF_CMD_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CMD_W-1:0]            cmd,
  input  logic                        sub,
  input  logic [NUM_CH*BIT_WIDTH-1:0] ain,
  input  logic [NUM_CH*BIT_WIDTH-1:0] bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*BIT_WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]           overflow,
  output logic [15:0]                 ovf_count
);

  logic s1_valid;
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic out_fire;
  op_e  op;

  // Stage 2 can take new data when it is empty or its result leaves now;
  // in_ready depends only on state and out_ready, never on in_valid.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign op       = sub ? OP_SUB : OP_ADD;

  // Stage 1 valid: set on accept, cleared when it moves on without refill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 valid: follows stage 1 whenever stage 2 may advance, else holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
    end
  end

  // Count delivered results that flagged any carry/borrow, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (out_fire && (|overflow) && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      logic lane_en;
      assign lane_en = lane_enabled(int'(cmd), gi, NUM_CH);

      adder_lane #(
        .BIT_WIDTH(BIT_WIDTH)
      ) u_lane (
        .clk      (clk),
        .reset_n  (reset_n),
        .s1_load  (in_fire),
        .s2_load  (s1_adv),
        .en       (lane_en),
        .op       (op),
        .a        (ain[gi*BIT_WIDTH +: BIT_WIDTH]),
        .b        (bin[gi*BIT_WIDTH +: BIT_WIDTH]),
        .dout     (dout[gi*BIT_WIDTH +: BIT_WIDTH]),
        .overflow (overflow[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_adder_array_pipe.sv
// Bench for adder_array_pipe: drives directed and random requests and checks
// every cycle against a transaction-level model (queue of expected results).
module tb_adder_array_pipe;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int NW = N * W;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] cmd;
  logic          sub;
  logic [NW-1:0] ain;
  logic [NW-1:0] bin;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] dout;
  logic [N-1:0]  overflow;
  logic [15:0]   ovf_count;

  adder_array_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd       (cmd),
    .sub       (sub),
    .ain       (ain),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .overflow  (overflow),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] d;
    logic [N-1:0]  o;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            out_n = 0;
  logic [15:0]   model_cnt = '0;
  logic          prev_stall = 1'b0;
  logic          cnt_pin = 1'b0;
  logic          final_done = 1'b0;
  logic [NW-1:0] prev_dout = '0;
  logic [N-1:0]  prev_ovf = '0;

  // Written only by the stimulus process.
  logic [NW-1:0] pin_d [0:2];
  logic [N-1:0]  pin_o [0:2];
  logic          done;
  logic          timeout_hit;
  logic          saw_block;
  logic          verbose;
  logic [NW-1:0] a_v;
  logic [NW-1:0] b_v;
  int            sent;
  logic          took;

  // Expected result of one request, straight from the arithmetic definition.
  function automatic exp_t model(input logic [CW-1:0] c, input logic s,
                                 input logic [NW-1:0] a, input logic [NW-1:0] b, input int cy);
    exp_t e;
    longint unsigned x;
    longint unsigned y;
    e.d   = '0;
    e.o   = '0;
    e.cyc = cy;
    for (int k = 0; k < N; k++) begin
      if (int'(c) == k || int'(c) == N) begin
        x = 64'(a[k*W +: W]);
        y = 64'(b[k*W +: W]);
        if (s) begin
          e.d[k*W +: W] = W'(x - y);
          e.o[k]        = (x < y);
        end else begin
          e.d[k*W +: W] = W'(x + y);
          e.o[k]        = ((x + y) >> W) != 0;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: inputs change just after posedge, so the values seen at
  // negedge are exactly those sampled by the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_ov;
    cyc++;
    if (!reset_n) begin
      chk("reset_out_valid", NW'(out_valid), '0);
      chk("reset_ovf_count", NW'(ovf_count), '0);
      chk("reset_overflow", NW'(overflow), '0);
      chk("reset_dout", dout, '0);
      q.delete();
      model_cnt  = '0;
      prev_stall = 1'b0;
      cnt_pin    = 1'b0;
    end else begin
      chk("ovf_count", NW'(ovf_count), NW'(model_cnt));
      if (cnt_pin) begin
        chk("ovf_count_first", NW'(ovf_count), NW'(16'd1));
        cnt_pin = 1'b0;
      end
      chk("in_ready", NW'(in_ready), NW'((q.size() < 2) || out_ready));
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = (q[0].cyc + 2 <= cyc);
      chk("out_valid", NW'(out_valid), NW'(exp_ov));
      if (prev_stall) begin
        chk("hold_dout", dout, prev_dout);
        chk("hold_overflow", NW'(overflow), NW'(prev_ovf));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("dout", dout, e.d);
        chk("overflow", NW'(overflow), NW'(e.o));
        if (out_n < 3) begin
          chk("pin_dout", dout, pin_d[out_n]);
          chk("pin_overflow", NW'(overflow), NW'(pin_o[out_n]));
        end
        if (out_n == 0) cnt_pin = 1'b1;
        if ((|e.o) && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        if (verbose) $display("OUT #%0d dout=%h ovf=%b", out_n, dout, overflow);
        out_n++;
      end
      if (in_valid && in_ready) q.push_back(model(cmd, sub, ain, bin, cyc));
      prev_stall = out_valid && !out_ready;
      prev_dout  = dout;
      prev_ovf   = overflow;
      if (done && !final_done) begin
        chk("drained", NW'(q.size()), '0);
        chk("no_timeout", NW'(timeout_hit), '0);
        chk("saw_in_ready_low", NW'(saw_block), NW'(1'b1));
        chk("ovf_count_saturated", NW'(ovf_count), NW'(16'hFFFF));
        final_done = 1'b1;
      end
    end
  end

  function automatic logic [NW-1:0] rnd_word();
    logic [NW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 7))
        0:       r[k*W +: W] = 32'h0000_0000;
        1:       r[k*W +: W] = 32'hFFFF_FFFF;
        2:       r[k*W +: W] = 32'h0000_FFFF;
        3:       r[k*W +: W] = 32'h0000_0001;
        default: r[k*W +: W] = $urandom();
      endcase
    end
    return r;
  endfunction

  // Hold a request until accepted (bounded); entered and left at posedge+1.
  task automatic send(input logic [CW-1:0] c, input logic s,
                      input logic [NW-1:0] a, input logic [NW-1:0] b);
    int   guard;
    logic acc;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    cmd      = c;
    sub      = s;
    ain      = a;
    bin      = b;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 200) begin
        timeout_hit = 1'b1;
        acc         = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clk         = 1'b0;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    cmd         = '0;
    sub         = 1'b0;
    ain         = '0;
    bin         = '0;
    out_ready   = 1'b1;
    done        = 1'b0;
    timeout_hit = 1'b0;
    saw_block   = 1'b0;
    verbose     = 1'b1;
    pin_d[0]    = '0;
    pin_o[0]    = 4'hF;
    pin_d[1]    = {32'h0, 32'hFFFF_FFFE, 64'h0};
    pin_o[1]    = 4'b0100;
    pin_d[2]    = {96'h0, 32'h0001_0000};
    pin_o[2]    = 4'b0000;

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // All lanes FFFF_FFFF + 1: wrap to zero with carry out everywhere.
    send(3'd4, 1'b0, {N{32'hFFFF_FFFF}}, {N{32'h0000_0001}});
    // Lane 2 only, 5 - 7 borrows.
    a_v = rnd_word();
    b_v = rnd_word();
    a_v[2*W +: W] = 32'd5;
    b_v[2*W +: W] = 32'd7;
    send(3'd2, 1'b1, a_v, b_v);
    // Lane 0 only, carry crosses from low half into high half.
    a_v = rnd_word();
    b_v = rnd_word();
    a_v[0 +: W] = 32'h0000_FFFF;
    b_v[0 +: W] = 32'h0000_0001;
    send(3'd0, 1'b0, a_v, b_v);
    idle(5);

    // Random traffic with random backpressure and all cmd values.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      cmd       = CW'($urandom_range(0, 7));
      sub       = 1'($urandom_range(0, 1));
      ain       = rnd_word();
      bin       = rnd_word();
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(5);

    // Eight back-to-back requests with the consumer stalled in cycles 3..5.
    sent = 0;
    took = 1'b1;
    for (int c = 0; c < 40 && !(sent == 8 && c > 14); c++) begin
      if (took) begin
        cmd = CW'($urandom_range(0, 4));
        sub = 1'($urandom_range(0, 1));
        ain = rnd_word();
        bin = rnd_word();
      end
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      @(negedge clk);
      took = in_valid && in_ready;
      if (took) sent++;
      if (in_valid && !in_ready) saw_block = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sent != 8) timeout_hit = 1'b1;
    idle(5);

    // Two requests in flight, then an asynchronous reset between edges.
    out_ready = 1'b0;
    send(3'd4, 1'b0, {N{32'hFFFF_FFFF}}, {N{32'h0000_0001}});
    send(3'd4, 1'b1, {N{32'h0000_0000}}, {N{32'h0000_0001}});
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    idle(6);

    // Long run of overflowing results to saturate the counter.
    verbose   = 1'b0;
    in_valid  = 1'b1;
    cmd       = 3'd4;
    sub       = 1'b0;
    ain       = {N{32'hFFFF_FFFF}};
    bin       = {N{32'h0000_0001}};
    out_ready = 1'b1;
    sent      = 0;
    for (int i = 0; i < 70100 && sent < 70000; i++) begin
      @(negedge clk);
      if (in_ready) sent++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (sent < 70000) timeout_hit = 1'b1;
    idle(5);

    done = 1'b1;
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
